ram_march_tester: RTL and testbench

Built-in self-test initiator for the 16×16 single-port synchronous RAM. It drives the RAM's write-enable, address and data-in port, reads data-out back, and runs a three-element March test: ascending write P, ascending read-P/write-~P, descending read-~P. It reports pass/fail, the first failing location and a mismatch count, and sits beside the RAM with a simple start/done handshake toward the host.

---
 rtl/ram_march_tester_if.sv | 44 ++++
 rtl/ram_march_tester.sv | 190 +++++++++++++++++++
 tb/tb_ram_march_tester.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_march_tester_if.sv
// ============================================================================
//  Module      : ram_march_tester_if
//  Description : Host handshake and RAM port bundle for the March tester.
//                The master side is the host plus RAM; the slave side is
//                the tester itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_march_tester_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  // Host handshake
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  pattern;
  logic              busy;
  logic              done;
  logic              pass;
  logic [5:0]        err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [WIDTH-1:0]  fail_data;
  logic [1:0]        fail_phase;
  // RAM port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output start, abort, pattern, mem_rdata,
    input  busy, done, pass, err_count, fail_addr, fail_data, fail_phase,
           mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, abort, pattern, mem_rdata,
    output busy, done, pass, err_count, fail_addr, fail_data, fail_phase,
           mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/ram_march_tester.sv
// ============================================================================
//  Module      : ram_march_tester
//  Description : BIST initiator running a three-element March test
//                (up W P; up R P / W ~P; down R ~P) on a 16x16 synchronous
//                RAM, reporting pass/fail, first failing location and a
//                mismatch count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_march_tester #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  ram_march_tester_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M1_WR = 3'd1,
    S_M2_RD = 3'd2,
    S_M2_WT = 3'd3,
    S_M2_WR = 3'd4,
    S_M3_RD = 3'd5,
    S_M3_WT = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [WIDTH-1:0]  pat_q,        pat_d;
  logic [5:0]        err_q,        err_d;
  logic [ADDR_W-1:0] fail_addr_q,  fail_addr_d;
  logic [WIDTH-1:0]  fail_data_q,  fail_data_d;
  logic [1:0]        fail_phase_q, fail_phase_d;
  logic              pass_q,       pass_d;
  logic              we_q,         we_d;
  logic [WIDTH-1:0]  wdata_q,      wdata_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;

  logic              mis;
  logic [1:0]        mis_phase;

  // Next-state, address sequencing, compare/capture and registered outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pat_d        = pat_q;
    err_d        = err_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_phase_d = fail_phase_q;
    pass_d       = pass_q;
    mis          = 1'b0;
    mis_phase    = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d      = S_M1_WR;
          addr_d       = ADDR_FIRST;
          pat_d        = bus.pattern;
          err_d        = 6'd0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          fail_phase_d = 2'd0;
          pass_d       = 1'b0;
        end
      end
      S_M1_WR: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_M2_RD;
          addr_d  = ADDR_FIRST;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      S_M2_RD: state_d = S_M2_WT;
      S_M2_WT: begin
        mis       = (bus.mem_rdata != pat_q);
        mis_phase = 2'd1;
        state_d   = S_M2_WR;
      end
      S_M2_WR: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_M3_RD;
          addr_d  = ADDR_LAST;
        end else begin
          state_d = S_M2_RD;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_M3_RD: state_d = S_M3_WT;
      S_M3_WT: begin
        mis       = (bus.mem_rdata != ~pat_q);
        mis_phase = 2'd2;
        if (addr_q == ADDR_FIRST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_M3_RD;
          addr_d  = addr_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Only the first mismatch of a run is recorded in detail
    if (mis) begin
      err_d = err_q + 6'd1;
      if (err_q == 6'd0) begin
        fail_addr_d  = addr_q;
        fail_data_d  = bus.mem_rdata;
        fail_phase_d = mis_phase;
      end
    end

    if (state_d == S_DONE) begin
      pass_d = (err_d == 6'd0);
    end

    // Abort drops the compare on the aborting edge and keeps partial results
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      addr_d       = ADDR_FIRST;
      err_d        = err_q;
      fail_addr_d  = fail_addr_q;
      fail_data_d  = fail_data_q;
      fail_phase_d = fail_phase_q;
      pass_d       = 1'b0;
    end

    we_d    = (state_d == S_M1_WR) || (state_d == S_M2_WR);
    wdata_d = (state_d == S_M1_WR) ? pat_d :
              (state_d == S_M2_WR) ? ~pat_d : '0;
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      pat_q        <= '0;
      err_q        <= 6'd0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_phase_q <= 2'd0;
      pass_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pat_q        <= pat_d;
      err_q        <= err_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_phase_q <= fail_phase_d;
      pass_q       <= pass_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_data  = fail_data_q;
  assign bus.fail_phase = fail_phase_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_march_tester.sv
// ============================================================================
//  Module      : tb_ram_march_tester
//  Description : Directed self-checking bench for ram_march_tester with a
//                behavioural 16x16 RAM and read-side fault injection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_march_tester;

  logic clk;
  logic rst;

  ram_march_tester_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  ram_march_tester #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = fault-free, 1 = bit0 stuck-at-0 on reads of address 9,
  // 2 = bit15 stuck-at-1 on every read
  int          fault_mode;
  logic [15:0] mem [16];

  function automatic logic [15:0] faulty(input logic [3:0] a, input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (fault_mode == 1 && a == 4'd9) r[0] = 1'b0;
    if (fault_mode == 2) r[15] = 1'b1;
    return r;
  endfunction

  // Behavioural synchronous RAM: write when we, otherwise register the read
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else            bus.mem_rdata     <= faulty(bus.mem_addr, mem[bus.mem_addr]);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next rising edge (edge 0); returns at edge0+1
  task automatic do_start(input logic [15:0] p);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = p;
    edge_step();
    bus.start   = 1'b0;
  endtask

  // Counts edges after `from` until done is seen; -1 when the bound expires
  task automatic wait_done(input int from, output int at);
    at = -1;
    for (int n = from + 1; n <= from + 200; n++) begin
      edge_step();
      if (bus.done === 1'b1) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.busy},   32'd0);
    chk({tag, "_done"},  {31'd0, bus.done},   32'd0);
    chk({tag, "_pass"},  {31'd0, bus.pass},   32'd0);
    chk({tag, "_err"},   {26'd0, bus.err_count}, 32'd0);
    chk({tag, "_faddr"}, {28'd0, bus.fail_addr}, 32'd0);
    chk({tag, "_fdata"}, {16'd0, bus.fail_data}, 32'd0);
    chk({tag, "_fph"},   {30'd0, bus.fail_phase}, 32'd0);
    chk({tag, "_we"},    {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_addr"},  {28'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
  endtask

  initial begin
    int at;
    bit saw;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = 16'h0000;
    fault_mode  = 0;
    repeat (2) edge_step();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fault-free run with A5A5
    do_start(16'hA5A5);
    chk("t1_busy_e0", {31'd0, bus.busy}, 32'd1);
    chk("t1_we_e0",   {31'd0, bus.mem_we}, 32'd1);
    repeat (15) edge_step();
    chk("t1_addr_e15",  {28'd0, bus.mem_addr}, 32'd15);
    chk("t1_wdata_e15", {16'd0, bus.mem_wdata}, 32'h0000A5A5);
    edge_step();
    chk("t1_we_e16",   {31'd0, bus.mem_we}, 32'd0);
    chk("t1_addr_e16", {28'd0, bus.mem_addr}, 32'd0);
    wait_done(16, at);
    chk("t1_done_edge", at, 96);
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("t1_pass", {31'd0, bus.pass}, 32'd1);
    chk("t1_err",  {26'd0, bus.err_count}, 32'd0);
    chk("t1_fph",  {30'd0, bus.fail_phase}, 32'd0);
    edge_step();
    chk("t1_done_pulse", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 16; i++) chk("t1_mem", {16'd0, mem[i]}, 32'h00005A5A);

    // abort alone in IDLE is ignored; start+abort together does not start
    @(negedge clk);
    bus.abort = 1'b1;
    edge_step();
    chk("idle_abort_pass", {31'd0, bus.pass}, 32'd1);
    @(negedge clk);
    bus.start = 1'b1;
    edge_step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("start_abort_pass", {31'd0, bus.pass}, 32'd1);

    // Stuck-at-0 on bit0 at address 9
    fault_mode = 1;
    do_start(16'hA5A5);
    chk("t2_pass_cleared", {31'd0, bus.pass}, 32'd0);
    wait_done(0, at);
    chk("t2_done_edge", at, 96);
    chk("t2_err",   {26'd0, bus.err_count}, 32'd1);
    chk("t2_faddr", {28'd0, bus.fail_addr}, 32'd9);
    chk("t2_fdata", {16'd0, bus.fail_data}, 32'h0000A5A4);
    chk("t2_fph",   {30'd0, bus.fail_phase}, 32'd1);
    chk("t2_pass",  {31'd0, bus.pass}, 32'd0);
    edge_step();

    // Stuck-at-1 on bit15 for every read
    fault_mode = 2;
    do_start(16'hFFFF);
    wait_done(0, at);
    chk("t3_done_edge", at, 96);
    chk("t3_err",   {26'd0, bus.err_count}, 32'd16);
    chk("t3_faddr", {28'd0, bus.fail_addr}, 32'd15);
    chk("t3_fdata", {16'd0, bus.fail_data}, 32'h00008000);
    chk("t3_fph",   {30'd0, bus.fail_phase}, 32'd2);
    chk("t3_pass",  {31'd0, bus.pass}, 32'd0);
    edge_step();
    fault_mode = 0;

    // Abort driven during cycle 40, taken at edge 41
    do_start(16'hA5A5);
    repeat (40) edge_step();
    bus.abort = 1'b1;
    edge_step();
    bus.abort = 1'b0;
    chk("ab_busy", {31'd0, bus.busy}, 32'd0);
    chk("ab_we",   {31'd0, bus.mem_we}, 32'd0);
    chk("ab_pass", {31'd0, bus.pass}, 32'd0);
    saw = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (bus.done === 1'b1) saw = 1'b1;
      edge_step();
    end
    chk("ab_no_done", {31'd0, saw}, 32'd0);
    do_start(16'hA5A5);
    wait_done(0, at);
    chk("ab_rerun_edge", at, 96);
    chk("ab_rerun_pass", {31'd0, bus.pass}, 32'd1);
    edge_step();

    // Mid-test start with another pattern is ignored
    do_start(16'h3C3C);
    repeat (19) edge_step();
    bus.start   = 1'b1;
    bus.pattern = 16'h0000;
    edge_step();
    bus.start   = 1'b0;
    wait_done(20, at);
    chk("ign_done_edge", at, 96);
    chk("ign_pass", {31'd0, bus.pass}, 32'd1);
    chk("ign_mem3", {16'd0, mem[3]}, 32'h0000C3C3);
    edge_step();

    // Asynchronous reset mid-test with a recorded failure
    fault_mode = 1;
    do_start(16'hA5A5);
    repeat (50) edge_step();
    chk("rst_pre_err",  {26'd0, bus.err_count}, 32'd1);
    chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;

    // Back-to-back runs, second start on the first IDLE edge
    do_start(16'h0000);
    wait_done(0, at);
    chk("bb1_done_edge", at, 96);
    chk("bb1_pass", {31'd0, bus.pass}, 32'd1);
    edge_step();
    chk("bb1_pass_held", {31'd0, bus.pass}, 32'd1);
    do_start(16'hFFFF);
    chk("bb2_pass_drop", {31'd0, bus.pass}, 32'd0);
    chk("bb2_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(0, at);
    chk("bb2_done_edge", at, 96);
    chk("bb2_pass", {31'd0, bus.pass}, 32'd1);
    chk("bb2_mem0", {16'd0, mem[0]}, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
